// File: rtl/mau_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, store
// types, exception codes and FSM states, plus small decode helpers.
package mau_pkg;

  localparam logic [1:0] SIZE_WORD    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_BYTE    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  localparam logic [2:0] STORE_WORD = 3'd0;
  localparam logic [2:0] STORE_HALF = 3'd1;
  localparam logic [2:0] STORE_BYTE = 3'd2;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_WORD: return (lsb != 2'd0);
      SIZE_HALF: return lsb[0];
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] store_type(input logic [1:0] size);
    case (size)
      SIZE_WORD: return STORE_WORD;
      SIZE_HALF: return STORE_HALF;
      SIZE_BYTE: return STORE_BYTE;
      default:   return STORE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane out of a memory word and sign- or
// zero-extends it to 32 bits; word accesses pass through untouched.
module load_extend
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      SIZE_HALF: data = {{16{is_signed & half_sel[15]}}, half_sel};
      SIZE_BYTE: data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a combinational data memory:
// accepts one request, checks alignment/range, performs one memory cycle.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWe,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic        Flush,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic [1:0]  RspExc,
  output logic [31:0] RspBadVAddr,
  output logic        MemWrite,
  output logic [2:0]  StoreType,
  output logic [31:0] Addr,
  output logic [31:0] DataW,
  input  logic [31:0] DataR,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge with ReqValid && ReqReady;
  // a response transfers on a rising edge with RspValid && RspReady. Flush
  // overrides both in the same cycle and cancels whatever is in flight.

  localparam logic [32:0] DM_LIMIT = 33'(DM_BYTES);

  state_t      state, state_next;
  logic        lat_we;
  logic        lat_signed;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_exc;
  logic [31:0] rsp_badvaddr;
  logic [31:0] load_data;
  logic        accept;
  logic        req_err;

  load_extend u_load_extend (
    .word      (DataR),
    .lane      (lat_addr[1:0]),
    .size      (lat_size),
    .is_signed (lat_signed),
    .data      (load_data)
  );

  assign accept  = (state == S_IDLE) && ReqValid && !Flush;
  assign req_err = (ReqSize == SIZE_ILLEGAL)
                || misaligned(ReqSize, ReqAddr[1:0])
                || ({1'b0, ReqAddr} >= DM_LIMIT);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: state_next = Flush ? S_IDLE : S_RESP;
      S_RESP:   if (Flush || RspReady) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lat_we       <= 1'b0;
      lat_signed   <= 1'b0;
      lat_size     <= 2'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      rsp_rdata    <= 32'd0;
      rsp_exc      <= EXC_NONE;
      rsp_badvaddr <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we     <= ReqWe;
            lat_signed <= ReqSigned;
            lat_size   <= ReqSize;
            lat_addr   <= ReqAddr;
            lat_wdata  <= ReqWData;
            // Faulting requests skip the memory cycle and respond next cycle.
            if (req_err) begin
              rsp_rdata    <= 32'd0;
              rsp_exc      <= ReqWe ? EXC_ADES : EXC_ADEL;
              rsp_badvaddr <= ReqAddr;
            end
          end
        end
        S_ACCESS: begin
          if (!Flush) begin
            rsp_rdata    <= lat_we ? 32'd0 : load_data;
            rsp_exc      <= EXC_NONE;
            rsp_badvaddr <= 32'd0;
          end
        end
        S_RESP: begin
          if (Flush || RspReady) begin
            rsp_rdata    <= 32'd0;
            rsp_exc      <= EXC_NONE;
            rsp_badvaddr <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs are live only during the single ACCESS cycle; reset
  // and Flush both kill the write strobe combinationally.
  always_comb begin
    MemWrite  = 1'b0;
    StoreType = 3'd0;
    Addr      = 32'd0;
    DataW     = 32'd0;
    if (state == S_ACCESS) begin
      MemWrite  = lat_we && !Flush && !reset;
      StoreType = store_type(lat_size);
      Addr      = lat_addr;
      DataW     = lat_wdata;
    end
  end

  assign ReqReady    = (state == S_IDLE) && !Flush;
  assign RspValid    = (state == S_RESP);
  assign RspRData    = rsp_rdata;
  assign RspExc      = rsp_exc;
  assign RspBadVAddr = rsp_badvaddr;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: a byte-array reference memory predicts
// every response, and a negedge monitor checks responses against a queue.
module tb_mem_access_unit;

  localparam int DM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWe;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        Flush;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspRData;
  logic [1:0]  RspExc;
  logic [31:0] RspBadVAddr;
  logic        MemWrite;
  logic [2:0]  StoreType;
  logic [31:0] Addr;
  logic [31:0] DataW;
  logic [31:0] DataR;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passes = 0;

  logic [65:0] exp_q[$];
  logic [7:0]  ref_mem [0:DM_BYTES-1];
  logic [31:0] dm [0:1023];
  logic        mem_init;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_BYTES(DM_BYTES)) dut (
    .clk         (clk),
    .reset       (reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqWe       (ReqWe),
    .ReqSize     (ReqSize),
    .ReqSigned   (ReqSigned),
    .ReqAddr     (ReqAddr),
    .ReqWData    (ReqWData),
    .Flush       (Flush),
    .RspValid    (RspValid),
    .RspReady    (RspReady),
    .RspRData    (RspRData),
    .RspExc      (RspExc),
    .RspBadVAddr (RspBadVAddr),
    .MemWrite    (MemWrite),
    .StoreType   (StoreType),
    .Addr        (Addr),
    .DataW       (DataW),
    .DataR       (DataR),
    .dbg_state   (dbg_state)
  );

  // Data memory seen by the DUT: combinational read, byte-lane write.
  assign DataR = dm[Addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++)
        dm[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    end else if (MemWrite) begin
      case (StoreType)
        3'd0: dm[Addr[11:2]] <= DataW;
        3'd1: if (Addr[1]) dm[Addr[11:2]][31:16] <= DataW[15:0];
              else         dm[Addr[11:2]][15:0]  <= DataW[15:0];
        3'd2: case (Addr[1:0])
                2'd0: dm[Addr[11:2]][7:0]   <= DataW[7:0];
                2'd1: dm[Addr[11:2]][15:8]  <= DataW[7:0];
                2'd2: dm[Addr[11:2]][23:16] <= DataW[7:0];
                default: dm[Addr[11:2]][31:24] <= DataW[7:0];
              endcase
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic ref_error(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd3) || (size == 2'd0 && a[1:0] != 2'd0) ||
           (size == 2'd1 && a[0]) || (a >= 32'(DM_BYTES));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size,
                                           input logic sgn);
    logic [31:0] v;
    int b;
    b = int'(a);
    v = 32'd0;
    case (size)
      2'd0: v = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      2'd1: begin
        v = {16'h0, ref_mem[b+1], ref_mem[b]};
        if (sgn && v[15]) v[31:16] = 16'hFFFF;
      end
      default: begin
        v = {24'h0, ref_mem[b]};
        if (sgn && v[7]) v[31:8] = 24'hFF_FFFF;
      end
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    int b;
    b = int'(a);
    ref_mem[b] = d[7:0];
    if (size != 2'd2) ref_mem[b+1] = d[15:8];
    if (size == 2'd0) begin
      ref_mem[b+2] = d[23:16];
      ref_mem[b+3] = d[31:24];
    end
  endtask

  // Response monitor: pops on every completed response handshake and checks
  // that a stalled response does not change while waiting.
  logic        hold_prev = 1'b0;
  logic [65:0] hold_val  = '0;

  always @(negedge clk) begin
    if (reset) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("rsp_held_valid", RspValid, 1'b1);
        check("rsp_held_stable", {RspRData, RspExc, RspBadVAddr}, hold_val);
      end
      if (RspValid && RspReady && !Flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got response %h expected none",
                   {RspRData, RspExc, RspBadVAddr});
        end else begin
          check("rsp_payload", {RspRData, RspExc, RspBadVAddr}, exp_q.pop_front());
        end
      end
      hold_prev <= RspValid && !RspReady && !Flush;
      hold_val  <= {RspRData, RspExc, RspBadVAddr};
    end
  end

  // mode: 0 normal, 1 flush in ACCESS, 2 flush in RESP, 3 reset in RESP,
  // 4 normal with a 3-cycle response stall, 5 reset in ACCESS.
  // k: cycles RspReady stays low once the response is up.
  // Entered and left just after a rising edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int mode_in, input int k_in);
    logic err;
    int   mode, k, resp_start, last;
    bit   done;
    err  = ref_error(size, addr);
    mode = mode_in;
    k    = k_in;
    if (mode == 4) begin mode = 0; k = 3; end
    if (err && (mode == 1 || mode == 5)) mode = 0;
    resp_start = err ? 1 : 2;
    last = resp_start + k;

    ReqValid = 1'b1; ReqWe = we; ReqSize = size; ReqSigned = sgn;
    ReqAddr = addr; ReqWData = wdata;
    @(negedge clk);
    check("req_ready_idle", ReqReady, 1'b1);
    @(posedge clk); #1;
    ReqValid = 1'b0;

    if (mode == 0) begin
      if (err) exp_q.push_back({32'h0, (we ? 2'd2 : 2'd1), addr});
      else     exp_q.push_back({(we ? 32'h0 : ref_load(addr, size, sgn)), 2'd0, 32'h0});
    end
    if (!err && we && mode != 1 && mode != 5) ref_store(addr, size, wdata);

    done = 1'b0;
    for (int c = 1; c <= last && !done; c++) begin
      Flush    = (mode == 1 && c == 1) || (mode == 2 && c == last);
      reset    = (mode == 5 && c == 1) || (mode == 3 && c == last);
      RspReady = (c == last);
      @(negedge clk);
      if (c == 1) begin
        check("rsp_valid_n1", RspValid, err);
        check("mem_write", MemWrite, !err && we && (mode == 0 || mode == 2 || mode == 3));
        if (!err && mode != 1 && mode != 5) begin
          check("access_addr", Addr, addr);
          check("access_dataw", DataW, wdata);
          check("access_storetype", StoreType, {1'b0, size});
        end else if (err) begin
          check("err_addr_zero", {Addr, DataW}, 64'h0);
        end
      end
      if (c >= resp_start && mode != 5) check("rsp_valid", RspValid, 1'b1);
      @(posedge clk); #1;
      if (mode == 1 || mode == 5) done = 1'b1;
    end

    Flush = 1'b0; reset = 1'b0; RspReady = 1'b0;
    @(negedge clk);
    check("rsp_valid_after", RspValid, 1'b0);
    check("req_ready_after", ReqReady, 1'b1);
    check("idle_mem_outs", {MemWrite, StoreType, Addr}, 36'h0);
    if (mode == 3 || mode == 5)
      check("rsp_outs_after_reset", {RspRData, RspExc, RspBadVAddr}, 66'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          md, r;
    reset = 1'b1; ReqValid = 1'b0; ReqWe = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
    ReqAddr = 32'h0; ReqWData = 32'h0; Flush = 1'b0; RspReady = 1'b0;
    for (int i = 0; i < DM_BYTES; i++) ref_mem[i] = 8'($urandom);
    mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_rsp", {RspValid, RspRData, RspExc, RspBadVAddr}, 67'h0);
    check("reset_mem", {MemWrite, StoreType, Addr, DataW}, 68'h0);
    check("reset_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("req_ready_reset", ReqReady, 1'b1);
    @(posedge clk); #1;

    do_req(1'b1, 2'd0, 1'b0, 32'h100, 32'h80FF_1234, 0, 0);
    do_req(1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 0, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h106, 32'h0, 0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h1000, 32'h1, 0, 2);
    do_req(1'b1, 2'd0, 1'b0, 32'h40, 32'hDEAD_BEEF, 1, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 4, 0);
    do_req(1'b0, 2'd2, 1'b1, 32'h101, 32'h0, 3, 1);
    do_req(1'b1, 2'd2, 1'b0, 32'h41, 32'h55, 5, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 0, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h1, 32'h0, 2, 1);

    // Flush while idle must block a presented request.
    ReqValid = 1'b1; ReqWe = 1'b0; ReqSize = 2'd0; ReqAddr = 32'h100; Flush = 1'b1;
    @(negedge clk);
    check("req_ready_flush", ReqReady, 1'b0);
    @(posedge clk); #1;
    ReqValid = 1'b0; Flush = 1'b0;
    @(negedge clk);
    check("flush_idle_no_accept", {ReqReady, RspValid}, 2'b10);
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'(DM_BYTES) + $urandom_range(0, 40);
      else if (r == 1) a = $urandom;
      else begin
        a = (r < 7) ? $urandom_range(0, 255) : $urandom_range(0, DM_BYTES - 1);
        if ($urandom_range(0, 5) != 0) a = (sz == 2'd0) ? (a & ~32'h3) :
                                           (sz == 2'd1) ? (a & ~32'h1) : a;
      end
      r = int'($urandom_range(0, 19));
      md = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : (r == 3) ? 5 : (r == 4) ? 4 : 0;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, md,
             int'($urandom_range(0, 2)));
    end

    check("queue_drained", 66'(exp_q.size()), 66'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
